// File: rtl/posit_pkg.sv
// Shared constants and FSM state type for the posit readout path.
// Rounding mode of the decoder is selected by POSIT_OUT_ROUND_EN.
package posit_pkg;

   localparam int PS = 16;
   localparam int ES = 0;

   localparam logic [PS-1:0] POSIT_NAR  = 16'h8000;
   localparam logic [PS-1:0] POSIT_ZERO = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      CONV,
      SEND
   } state_t;

endpackage

// File: rtl/posit_stream_out_conv.sv
// posit<16,0> to uint8 decoder: regime count, shift, round, saturate.
// Round-to-nearest-even with POSIT_OUT_ROUND_EN, truncation otherwise.
module posit16_to_uint8
   import posit_pkg::*;
(
   input  logic [PS-1:0] posit,
   output logic [7:0]    val,
   output logic          is_nar
);

`ifdef POSIT_OUT_ROUND_EN
   localparam bit RND_EN = 1'b1;
`else
   localparam bit RND_EN = 1'b0;
`endif

   logic              run;
   logic [4:0]        m;
   logic signed [5:0] k;
   logic [PS-2:0]     frac;
   logic [15:0]       mant;
   logic [3:0]        sh;
   logic [23:0]       w;
   logic              rnd;
   logic [8:0]        sum;

   always_comb begin
      m   = '0;
      run = 1'b1;
      for (int i = PS - 2; i >= 0; i--) begin
         if (run && posit[i] == posit[PS-2]) m = m + 5'd1;
         else run = 1'b0;
      end
      k = posit[PS-2] ? $signed({1'b0, m}) - 6'sd1
                      : -$signed({1'b0, m});
      frac = posit[PS-2:0] << (m + 5'd1);
      mant = {1'b1, frac};
      // w[23:16] is the integer part once 1.f is scaled by 2^k (k in -1..7)
      sh   = k[3:0] + 4'd1;
      w    = {8'd0, mant} << sh;
      rnd  = RND_EN & w[15] & ((|w[14:0]) | w[16]);
      sum  = {1'b0, w[23:16]} + {8'd0, rnd};
   end

   always_comb begin
      is_nar = (posit == POSIT_NAR);
      val    = '0;
      if (posit == POSIT_ZERO || posit[PS-1]) val = '0;
      else if (k >= 6'sd8)                    val = 8'hFF;
      else if (k <= -6'sd2)                   val = '0;
      else if (sum[8])                        val = 8'hFF;
      else                                    val = sum[7:0];
   end

endmodule

// File: rtl/posit_stream_out.sv
// Frame readout: fetch posit pixels over req/ack, emit uint8 on AXI-Stream.
// POSIT_OUT_ROUND_EN selects round-to-nearest-even instead of truncation.
module posit_stream_out #(
   parameter int N       = 8,
   parameter int PS      = 16,
   parameter int ES      = 0,
   parameter int NUM_PIX = 64,
   parameter int AW      = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pipe_read_req,
   output logic [AW-1:0] pipe_read_addr,
   input  logic [PS-1:0] pipe_read_data,
   input  logic          pipe_read_ack,
   output logic          tx_axis_tvalid,
   output logic [N-1:0]  tx_axis_tdata,
   output logic          tx_axis_tlast,
   input  logic          tx_axis_tready,
   output logic          nar_seen
);

   import posit_pkg::*;

   if (ES != 0 || N != 8 || PS != 16) begin : g_bad_cfg
      $error("posit_stream_out supports only posit<16,0> to uint8");
   end

   state_t        state, state_nxt;
   logic [AW-1:0] addr;
   logic [PS-1:0] pix;
   logic [7:0]    conv;
   logic          conv_nar;
   logic          hs;
   logic          at_last;

   posit16_to_uint8 u_conv (
      .posit  (pix),
      .val    (conv),
      .is_nar (conv_nar)
   );

   assign hs      = tx_axis_tvalid & tx_axis_tready;
   assign at_last = (addr == AW'(NUM_PIX - 1));

   assign busy           = (state != IDLE);
   assign pipe_read_req  = (state == REQ);
   assign pipe_read_addr = addr;
   assign tx_axis_tvalid = (state == SEND);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start)         state_nxt = REQ;
         REQ:  if (pipe_read_ack) state_nxt = CONV;
         CONV:                    state_nxt = SEND;
         SEND: if (hs)            state_nxt = tx_axis_tlast ? IDLE : REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr          <= '0;
         pix           <= '0;
         tx_axis_tdata <= '0;
         tx_axis_tlast <= 1'b0;
         done          <= 1'b0;
         nar_seen      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) begin
               addr     <= '0;
               nar_seen <= 1'b0;
            end
            REQ: if (pipe_read_ack) pix <= pipe_read_data;
            CONV: begin
               tx_axis_tdata <= conv;
               tx_axis_tlast <= at_last;
               if (conv_nar) nar_seen <= 1'b1;
            end
            SEND: if (hs) begin
               if (tx_axis_tlast) done <= 1'b1;
               else               addr <= addr + 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_posit_stream_out.sv
// Directed bench for posit_stream_out with a req/ack memory model and AXIS sink.
// Expected pixel values follow POSIT_OUT_ROUND_EN when it is defined.
`timescale 1ns/1ps
module tb_posit_stream_out;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, req, ack = 1'b0;
   logic [5:0]  raddr;
   logic [15:0] rdata = 16'h8000;
   logic        tvalid, tlast, nar;
   logic [7:0]  tdata;
   logic        tready = 1'b1;

   always #5 clk = ~clk;

   posit_stream_out dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .pipe_read_req  (req),
      .pipe_read_addr (raddr),
      .pipe_read_data (rdata),
      .pipe_read_ack  (ack),
      .tx_axis_tvalid (tvalid),
      .tx_axis_tdata  (tdata),
      .tx_axis_tlast  (tlast),
      .tx_axis_tready (tready),
      .nar_seen       (nar)
   );

`ifdef POSIT_OUT_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic [15:0] mem   [64];
   logic [7:0]  exp_d [64];
   int          maxd = 0;
   int          wc = 0;
   bit          rdy_rand = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [7:0]  beat_d [$];
   logic        beat_l [$];
   int          addr_q [$];
   int          done_cnt = 0;
   int          stall_err = 0;
   logic        stl = 1'b0;
   logic [7:0]  stl_d;
   logic        stl_l;

   // memory: ack one or more cycles after seeing req; junk data when idle
   always @(posedge clk) begin
      ack   <= 1'b0;
      rdata <= 16'h8000;
      if (req && !ack) begin
         if (wc == 0) begin
            ack   <= 1'b1;
            rdata <= mem[raddr];
            wc    <= (maxd == 0) ? 0 : int'($urandom_range(maxd, 0));
         end else begin
            wc <= wc - 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_rand) tready = 1'($urandom_range(1, 0));
   end

   always @(posedge clk) begin
      #2;
      if (stl && !reset)
         if (!tvalid || tdata !== stl_d || tlast !== stl_l) stall_err++;
      stl   = tvalid && !tready;
      stl_d = tdata;
      stl_l = tlast;
      if (tvalid && tready) begin
         beat_d.push_back(tdata);
         beat_l.push_back(tlast);
      end
      if (req && ack) addr_q.push_back(int'(raddr));
      if (done) done_cnt++;
   end

   task automatic load_frame();
      for (int i = 0; i < 64; i++) begin
         mem[i]   = 16'h4000;
         exp_d[i] = 8'd1;
      end
      mem[0]  = 16'h4000; exp_d[0]  = 8'd1;
      mem[1]  = 16'h6000; exp_d[1]  = 8'd2;
      mem[2]  = 16'h7000; exp_d[2]  = 8'd4;
      mem[3]  = 16'h7FA4; exp_d[3]  = 8'd200;
      mem[4]  = 16'h5000; exp_d[4]  = RND ? 8'd2 : 8'd1;
      mem[5]  = 16'h2000; exp_d[5]  = 8'd0;
      mem[6]  = 16'h3000; exp_d[6]  = RND ? 8'd1 : 8'd0;
      mem[7]  = 16'h7FFF; exp_d[7]  = 8'd255;
      mem[8]  = 16'hC000; exp_d[8]  = 8'd0;
      mem[9]  = 16'h0000; exp_d[9]  = 8'd0;
      mem[10] = 16'h7F00; exp_d[10] = 8'd64;
      mem[11] = 16'h7FC0; exp_d[11] = 8'd255;
      mem[12] = 16'h7F80; exp_d[12] = 8'd128;
      mem[13] = 16'h1000; exp_d[13] = 8'd0;
      mem[14] = 16'h7FBF; exp_d[14] = 8'd254;
      mem[15] = 16'h7F7F; exp_d[15] = RND ? 8'd128 : 8'd127;
      mem[16] = 16'h7F7D; exp_d[16] = 8'd126;
      mem[17] = 16'h5800; exp_d[17] = RND ? 8'd2 : 8'd1;
      mem[18] = 16'h2800; exp_d[18] = RND ? 8'd1 : 8'd0;
      mem[63] = 16'h7FA4; exp_d[63] = 8'd200;
   endtask

   task automatic run_frame(input int budget, input bit poke, output int cyc);
      beat_d.delete();
      beat_l.delete();
      addr_q.delete();
      done_cnt  = 0;
      stall_err = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < budget) begin
         start = poke && (cyc % 37 == 5);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({req, raddr, tvalid, tdata, tlast, busy, done, nar} !== '0) begin
         n_bad++;
         $display("FAIL reset_vals: got req=%b addr=%0d tv=%b td=%0d tl=%b busy=%b done=%b nar=%b want all 0",
                  req, raddr, tvalid, tdata, tlast, busy, done, nar);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_latency();
      int n;
      load_frame();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({req, busy, raddr} !== {1'b1, 1'b1, 6'd0}) begin
         n_bad++;
         $display("FAIL start_lat: got req=%b busy=%b addr=%0d want 1 1 0", req, busy, raddr);
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (tvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_plus1: got tvalid=%b want 0", tvalid);
      end
      @(negedge clk);
      n_cmp++;
      if ({tvalid, tdata} !== {1'b1, 8'd1}) begin
         n_bad++;
         $display("FAIL ack_plus2: got tvalid=%b tdata=%0d want 1 1", tvalid, tdata);
      end
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL lat_done: got done=%b want 1 within budget", done);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frame();
      int cyc;
      load_frame();
      run_frame(600, 1'b0, cyc);
      n_cmp++;
      if (cyc !== 257) begin
         n_bad++;
         $display("FAIL frame_cycles: got %0d want 257", cyc);
      end
      n_cmp++;
      if (beat_d.size() !== 64 || addr_q.size() !== 64) begin
         n_bad++;
         $display("FAIL frame_count: got beats=%0d addrs=%0d want 64 64", beat_d.size(), addr_q.size());
      end
      for (int i = 0; i < beat_d.size() && i < 64; i++) begin
         n_cmp++;
         if ({beat_l[i], beat_d[i]} !== {i == 63, exp_d[i]}) begin
            n_bad++;
            $display("FAIL frame_beat%0d: got last=%b data=%0d want last=%b data=%0d",
                     i, beat_l[i], beat_d[i], i == 63, exp_d[i]);
         end
      end
      for (int i = 0; i < addr_q.size(); i++) begin
         n_cmp++;
         if (addr_q[i] !== i) begin
            n_bad++;
            $display("FAIL frame_addr%0d: got %0d want %0d", i, addr_q[i], i);
         end
      end
      n_cmp++;
      if ({done_cnt, busy, nar} !== {32'd1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL frame_end: got done_cnt=%0d busy=%b nar=%b want 1 0 0", done_cnt, busy, nar);
      end
   endtask

   task automatic test_nar();
      int cyc;
      load_frame();
      mem[5] = 16'h8000;
      run_frame(600, 1'b0, cyc);
      n_cmp++;
      if (beat_d.size() !== 64 || beat_d[5] !== 8'd0) begin
         n_bad++;
         $display("FAIL nar_data: got beats=%0d d5=%0d want 64 0", beat_d.size(), beat_d[5]);
      end
      n_cmp++;
      if (nar !== 1'b1) begin
         n_bad++;
         $display("FAIL nar_sticky: got %b want 1", nar);
      end
      load_frame();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (nar !== 1'b0) begin
         n_bad++;
         $display("FAIL nar_clear: got %b want 0", nar);
      end
      cyc = 0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({done, nar, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL nar_frame2: got done=%b nar=%b busy=%b want 0 0 0", done, nar, busy);
      end
   endtask

   task automatic test_start_busy();
      int cyc;
      load_frame();
      run_frame(600, 1'b1, cyc);
      n_cmp++;
      if (cyc !== 257 || done_cnt !== 1) begin
         n_bad++;
         $display("FAIL busy_start_timing: got cyc=%0d done_cnt=%0d want 257 1", cyc, done_cnt);
      end
      n_cmp++;
      if (addr_q.size() !== 64) begin
         n_bad++;
         $display("FAIL busy_start_addrs: got %0d addrs want 64", addr_q.size());
      end
      for (int i = 0; i < addr_q.size(); i++) begin
         n_cmp++;
         if (addr_q[i] !== i) begin
            n_bad++;
            $display("FAIL busy_start_addr%0d: got %0d want %0d", i, addr_q[i], i);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int cyc;
      load_frame();
      done_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(req && raddr == 6'd10) && n < 200) begin
         @(negedge clk);
         n++;
      end
      tready = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({tvalid, raddr} !== {1'b1, 6'd10}) begin
         n_bad++;
         $display("FAIL mid_send10: got tvalid=%b addr=%0d want 1 10", tvalid, raddr);
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({tvalid, busy, req, raddr, tdata, tlast, done} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: got tv=%b busy=%b req=%b addr=%0d td=%0d tl=%b done=%b want all 0",
                  tvalid, busy, req, raddr, tdata, tlast, done);
      end
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      tready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, done_cnt} !== {1'b0, 32'd0}) begin
         n_bad++;
         $display("FAIL mid_start_in_reset: got busy=%b done_cnt=%0d want 0 0", busy, done_cnt);
      end
      run_frame(600, 1'b0, cyc);
      n_cmp++;
      if (addr_q.size() !== 64 || addr_q[0] !== 0 || addr_q[63] !== 63 || cyc !== 257) begin
         n_bad++;
         $display("FAIL mid_restart: got n=%0d first=%0d cyc=%0d want 64 0 257",
                  addr_q.size(), addr_q[0], cyc);
      end
   endtask

   task automatic test_stall();
      int cyc;
      load_frame();
      maxd = 5;
      rdy_rand = 1'b1;
      run_frame(6000, 1'b0, cyc);
      rdy_rand = 1'b0;
      tready = 1'b1;
      maxd = 0;
      n_cmp++;
      if (done_cnt !== 1 || stall_err !== 0) begin
         n_bad++;
         $display("FAIL stall_done: got done_cnt=%0d stall_err=%0d want 1 0", done_cnt, stall_err);
      end
      n_cmp++;
      if (beat_d.size() !== 64 || addr_q.size() !== 64) begin
         n_bad++;
         $display("FAIL stall_count: got beats=%0d addrs=%0d want 64 64", beat_d.size(), addr_q.size());
      end
      for (int i = 0; i < beat_d.size() && i < 64; i++) begin
         n_cmp++;
         if ({beat_l[i], beat_d[i]} !== {i == 63, exp_d[i]}) begin
            n_bad++;
            $display("FAIL stall_beat%0d: got last=%b data=%0d want last=%b data=%0d",
                     i, beat_l[i], beat_d[i], i == 63, exp_d[i]);
         end
      end
      for (int i = 0; i < addr_q.size(); i++) begin
         n_cmp++;
         if (addr_q[i] !== i) begin
            n_bad++;
            $display("FAIL stall_addr%0d: got %0d want %0d", i, addr_q[i], i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_frame();
      test_nar();
      test_start_busy();
      test_reset_mid();
      test_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/posit_stream_out.md
# posit_stream_out

Readout stage directly downstream of the image memory wrapper. On a start pulse it reads `NUM_PIX` 16-bit posit<16,0> pixels from image memory over the req/ack pipe, one at a time. Each pixel is converted to an unsigned 8-bit integer and emitted on an AXI-Stream master port, with `tlast` on the final pixel. It is the inverse path of the int-to-posit ingest stage and closes the loop back to the host.

## Interface
- `N`, 8: output integer width (`tx_axis_tdata`).
- `PS`, 16: posit width.
- `ES`, 0: posit exponent bits; only 0 is supported.
- `NUM_PIX`, 64: pixels per frame (8x8 image).
- `AW`, 6: read address width, equal to clog2(`NUM_PIX`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins frame readout. Ignored while `busy`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last beat handshakes.
- `pipe_read_req`  out  1  read request to image memory.
- `pipe_read_addr`  out  `AW`  pixel index, 0..`NUM_PIX`-1.
- `pipe_read_data`  in  `PS`  posit pixel. Valid only in a cycle with `pipe_read_ack` high.
- `pipe_read_ack`  in  1  one-cycle acknowledge from memory.
- `tx_axis_tvalid`  out  1
- `tx_axis_tdata`  out  `N`
- `tx_axis_tlast`  out  1
- `tx_axis_tready`  in  1
- `nar_seen`  out  1  sticky; set when any NaR pixel is read. Cleared by `start` or `reset`.

## Operation
- FSM states: IDLE, REQ, CONV, SEND.
- IDLE: on `start`, go to REQ. Set addr=0, `busy`=1, clear `nar_seen`.
- REQ: hold `pipe_read_req`=1 and a stable `pipe_read_addr` until `pipe_read_ack`. In the ack cycle, capture `pipe_read_data`, drop req, go to CONV.
- CONV: decode the captured posit and register the result into `tdata` and `tlast` (`tlast` = addr==`NUM_PIX`-1). Go to SEND.
- SEND: hold `tvalid`=1 with stable data until `tready`.
  - On handshake with `tlast`: go to IDLE, pulse `done`, set `busy`=0.
  - On handshake otherwise: increment addr and go to REQ.
- Conversion rules. The value is 2^k·(1.f). Regime is a run of m identical bits after the sign bit: a run of ones gives k=m-1, a run of zeros gives k=-m.
  - 0x0000 → 0.
  - 0x8000 (NaR) → 0, and set `nar_seen`.
  - Sign bit set (negative) → 0.
  - k≥8 → 255 (saturate).
  - k≤-2 → 0.
  - k=-1 → value in [0.5,1), rounds per the rounding rule.
  - 0≤k≤7 → integer part = (1.f)<<k, then round. A rounded result of 256 saturates to 255.
- Rounding: round-to-nearest, ties-to-even, applied to the guard bit and sticky bits below the integer point.
- Reset mid-frame: FSM goes to IDLE and all outputs take reset values in the next cycle. No partial `done` pulse is generated.

## Timing
- Reset values: `pipe_read_req`=0, `pipe_read_addr`=0, `tx_axis_tvalid`=0, `tx_axis_tdata`=0, `tx_axis_tlast`=0, `busy`=0, `done`=0, `nar_seen`=0.
- `start` in cycle t: `pipe_read_req`=1 in cycle t+1.
- Ack in cycle a: `tvalid`=1 in cycle a+2. Minimum per pixel is 4 cycles with zero-wait memory and `tready` held high.
- `tvalid` never drops, and `tdata`/`tlast` never change, until the handshake completes (AXI-Stream rule).
- `done` is asserted in the cycle after the last handshake.
- `pipe_read_ack` seen outside REQ is ignored.
- `start` asserted together with a `reset` cycle is ignored.

## Configuration
- `POSIT_OUT_ROUND_EN` defined: round-to-nearest-even as specified above.
- `POSIT_OUT_ROUND_EN` undefined: truncate toward zero (fraction bits below the integer point are discarded). Saturation and NaR handling are unchanged.

## Structure
- Shared package `posit_pkg` holds:
  - constants `PS`, `ES`, `POSIT_NAR` (16'h8000) and `POSIT_ZERO`;
  - the FSM state enum typedef.
- One sub-module, `posit16_to_uint8`: a purely combinational decoder (regime count, shift, round, saturate) that also outputs an `is_nar` flag. It is instantiated in CONV.

## Test plan
- Frame of 0x4000, 0x6000, 0x7000, 0x7FA4 with `tready`=1 → tdata 1, 2, 4, 200. `tlast` only on the beat at index `NUM_PIX`-1; a single `done` pulse.
- 0x5000 (1.5) → 2 and 0x2000 (0.5) → 0. 0x3000 (0.75) → 1. With `POSIT_OUT_ROUND_EN` undefined, 0x5000 → 1.
- 0x7FFF → 255; 0xC000 (-1) → 0; 0x8000 → 0 and `nar_seen`=1 until the next `start`.
- `tready` toggled randomly and memory ack delayed 0–5 cycles → `tdata` stays stable while stalled, no beat is lost, and the address sequence is 0..63.
- `reset` asserted during SEND at pixel 10 → next cycle `tvalid`=0 and `busy`=0. A new `start` reads from addr 0.
- `start` pulsed while `busy` → ignored; address sequence and `done` timing are unchanged.
